// File: rtl/dsp_spi_responder.sv
// SPI mode-0 responder, all pins oversampled on sysclk; 4 status bytes (0-3), 4 control bytes (4-7).
// Optional frame-stall timeout is built when DSP_SPI_TIMEOUT_EN is defined.
module dsp_spi_responder #(
    parameter logic [31:0] CTRL_RESET     = 32'h0000_0000,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
    input  logic        sysclk_i,
    input  logic        reset_i,
    input  logic        spi_clk_i,
    input  logic        spi_mosi_i,
    input  logic        spi_cs_inv_i,
    output logic        spi_miso_o,
    input  logic [31:0] status_in_i,
    output logic [31:0] ctrl_out_o,
    output logic        wr_stb_o,
    output logic [1:0]  wr_addr_o,
    output logic        timeout_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // sclk_q = {prev, sync, meta}; the edge is seen one flop past the synchroniser
    logic [2:0] sclk_q;
    logic [1:0] mosi_q;
    logic [1:0] cs_q;

    logic [1:0]  state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  rx_sr_q, rx_sr_d;
    logic [7:0]  tx_sr_q, tx_sr_d;
    logic        rw_q, rw_d;
    logic [2:0]  addr_q, addr_d;
    logic        miso_q, miso_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic        wr_stb_q, wr_stb_d;
    logic [1:0]  wr_addr_q, wr_addr_d;

    logic       sclk_rise, sclk_fall, cs_hi, mosi_s;
    logic [7:0] rx_byte;
    logic [2:0] cmd_addr;
    logic [7:0] rd_byte;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_hi     = cs_q[1];
    assign mosi_s    = mosi_q[1];
    assign rx_byte   = {rx_sr_q, mosi_s};
    assign cmd_addr  = rx_byte[2:0];
    assign rd_byte   = cmd_addr[2] ? ctrl_q[{cmd_addr[1:0], 3'b000} +: 8]
                                   : status_in_i[{cmd_addr[1:0], 3'b000} +: 8];

`ifdef DSP_SPI_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;
    logic        timeout_q, timeout_d;
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_sr_d   = rx_sr_q;
        tx_sr_d   = tx_sr_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        miso_d    = miso_q;
        ctrl_d    = ctrl_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;

        if (cs_hi) begin
            // CS has priority over any coincident SCLK edge, so a racing 16th rise never writes
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
            rx_sr_d   = 7'd0;
            miso_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_CMD;
                    bit_cnt_d = 4'd0;
                    rx_sr_d   = 7'd0;
                    miso_d    = 1'b0;
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        rx_sr_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            rw_d    = rx_byte[7];
                            addr_d  = cmd_addr;
                            tx_sr_d = rx_byte[7] ? rd_byte : 8'd0;
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (sclk_rise) begin
                        rx_sr_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd15) begin
                            bit_cnt_d = bit_cnt_q;
                            state_d   = ST_DONE;
                            if (!rw_q && addr_q[2]) begin
                                ctrl_d[{addr_q[1:0], 3'b000} +: 8] = rx_byte;
                                wr_stb_d  = 1'b1;
                                wr_addr_d = addr_q[1:0];
                            end
                        end
                    end else if (sclk_fall) begin
                        miso_d  = tx_sr_q[7];
                        tx_sr_d = {tx_sr_q[6:0], 1'b0};
                    end
                end
                default: begin
                    miso_d = 1'b0;
                end
            endcase
        end

`ifdef DSP_SPI_TIMEOUT_EN
        timeout_d = 1'b0;
        tmo_d     = 16'd0;
        if (!cs_hi && (state_q == ST_CMD || state_q == ST_DATA) && !sclk_rise && !sclk_fall) begin
            if (tmo_q == TIMEOUT_CYCLES - 16'd1) begin
                timeout_d = 1'b1;
                state_d   = ST_DONE;
                miso_d    = 1'b0;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
        end
`endif
    end

    always_ff @(posedge sysclk_i or posedge reset_i) begin
        if (reset_i) begin
            sclk_q    <= 3'b000;
            mosi_q    <= 2'b00;
            cs_q      <= 2'b11;
            state_q   <= ST_IDLE;
            bit_cnt_q <= 4'd0;
            rx_sr_q   <= 7'd0;
            tx_sr_q   <= 8'd0;
            rw_q      <= 1'b0;
            addr_q    <= 3'd0;
            miso_q    <= 1'b0;
            ctrl_q    <= CTRL_RESET;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= 2'd0;
        end else begin
            sclk_q    <= {sclk_q[1:0], spi_clk_i};
            mosi_q    <= {mosi_q[0], spi_mosi_i};
            cs_q      <= {cs_q[0], spi_cs_inv_i};
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_sr_q   <= rx_sr_d;
            tx_sr_q   <= tx_sr_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            miso_q    <= miso_d;
            ctrl_q    <= ctrl_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
        end
    end

`ifdef DSP_SPI_TIMEOUT_EN
    always_ff @(posedge sysclk_i or posedge reset_i) begin
        if (reset_i) begin
            tmo_q     <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign spi_miso_o = miso_q;
    assign ctrl_out_o = ctrl_q;
    assign wr_stb_o   = wr_stb_q;
    assign wr_addr_o  = wr_addr_q;

endmodule

// File: tb/tb_dsp_spi_responder.sv
// Self-checking bench for dsp_spi_responder: directed frames plus randomized frames
// checked against a byte-level model of the register map.
module tb_dsp_spi_responder;

    localparam logic [31:0] CtrlReset = 32'hC0DE_0001;

    logic        clk = 1'b0;
    logic        rst, sclk, mosi, cs_n, miso, wr_stb, timeout;
    logic [31:0] status, ctrl;
    logic [1:0]  wr_addr;

    int n_checks = 0;
    int n_fail   = 0;
    int stb_cnt  = 0;
    int to_cnt   = 0;

    // Reference model state
    logic [7:0] m_ctrl [4];
    logic [1:0] m_wa;

    always #5 clk = ~clk;

    dsp_spi_responder #(
        .CTRL_RESET    (CtrlReset),
        .TIMEOUT_CYCLES(16'd64)
    ) dut (
        .sysclk_i    (clk),
        .reset_i     (rst),
        .spi_clk_i   (sclk),
        .spi_mosi_i  (mosi),
        .spi_cs_inv_i(cs_n),
        .spi_miso_o  (miso),
        .status_in_i (status),
        .ctrl_out_o  (ctrl),
        .wr_stb_o    (wr_stb),
        .wr_addr_o   (wr_addr),
        .timeout_o   (timeout)
    );

    always @(negedge clk) begin
        if (wr_stb)  stb_cnt <= stb_cnt + 1;
        if (timeout) to_cnt  <= to_cnt + 1;
    end

    function automatic logic [31:0] m_ctrl_word();
        return {m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]};
    endfunction

    // Frame-level model: bits[23:16]=command, bits[15:8]=data, exp[i] = MISO seen at rise i
    function automatic void model(input int nbits, input logic [23:0] bits,
                                  output logic [23:0] exp, output int exp_stb);
        logic [7:0] cmd  = bits[23:16];
        logic [7:0] data = bits[15:8];
        int         a    = int'(cmd[2:0]);
        logic [7:0] rd;
        exp     = '0;
        exp_stb = 0;
        if (!cmd[7])   rd = 8'h00;
        else if (a < 4) rd = status[8*a +: 8];
        else           rd = m_ctrl[a-4];
        for (int i = 8; i < 16 && i < nbits; i++) exp[i] = rd[15-i];
        if (nbits >= 16 && !cmd[7] && a >= 4) begin
            m_ctrl[a-4] = data;
            m_wa        = 2'(a - 4);
            exp_stb     = 1;
        end
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int nbits, input logic [23:0] bits, input bit keep_cs,
                        output logic [23:0] got);
        got  = '0;
        cs_n = 1'b0;
        wait_clk(4);
        for (int i = 0; i < nbits; i++) begin
            mosi = bits[23-i];
            wait_clk(8);
            sclk   = 1'b1;
            got[i] = miso;
            wait_clk(8);
            sclk = 1'b0;
        end
        wait_clk(4);
        if (!keep_cs) begin
            cs_n = 1'b1;
            wait_clk(8);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (ctrl !== CtrlReset) begin
            n_fail++; $display("FAIL reset_ctrl got %h want %h", ctrl, CtrlReset);
        end
        n_checks++;
        if ({miso, wr_stb, wr_addr, timeout} !== 5'b0) begin
            n_fail++; $display("FAIL reset_outputs got %b want 00000", {miso, wr_stb, wr_addr, timeout});
        end
    endtask

    task automatic test_write_basic();
        logic [23:0] got, exp; int es, s0;
        s0 = stb_cnt;
        model(16, 24'h05A500, exp, es);
        xfer(16, 24'h05A500, 1'b0, got);
        n_checks++;
        if (ctrl !== m_ctrl_word()) begin
            n_fail++; $display("FAIL write_basic_ctrl got %h want %h", ctrl, m_ctrl_word());
        end
        n_checks++;
        if (stb_cnt - s0 != es) begin
            n_fail++; $display("FAIL write_basic_stb got %0d want %0d", stb_cnt - s0, es);
        end
        n_checks++;
        if (wr_addr !== 2'd1) begin
            n_fail++; $display("FAIL write_basic_addr got %0d want 1", wr_addr);
        end
    endtask

    task automatic test_read_status();
        logic [23:0] got, exp; int es, s0;
        status = 32'h1234_5678;
        s0 = stb_cnt;
        model(16, 24'h820000, exp, es);
        xfer(16, 24'h820000, 1'b0, got);
        n_checks++;
        if (got !== exp) begin
            n_fail++; $display("FAIL read_status_miso got %h want %h", got, exp);
        end
        n_checks++;
        if (stb_cnt != s0) begin
            n_fail++; $display("FAIL read_status_stb got %0d want 0", stb_cnt - s0);
        end
    endtask

    task automatic test_write_status();
        logic [23:0] got, exp; int es, s0;
        s0 = stb_cnt;
        model(16, 24'h02FF00, exp, es);
        xfer(16, 24'h02FF00, 1'b0, got);
        n_checks++;
        if (ctrl !== m_ctrl_word() || stb_cnt != s0) begin
            n_fail++; $display("FAIL write_status_ignored got ctrl %h stb %0d want ctrl %h stb 0",
                               ctrl, stb_cnt - s0, m_ctrl_word());
        end
        model(16, 24'h820000, exp, es);
        xfer(16, 24'h820000, 1'b0, got);
        n_checks++;
        if (got !== exp) begin
            n_fail++; $display("FAIL write_status_readback got %h want %h", got, exp);
        end
    endtask

    task automatic test_abort();
        logic [23:0] got, exp; int es, s0;
        s0 = stb_cnt;
        model(12, 24'h043C00, exp, es);
        xfer(12, 24'h043C00, 1'b0, got);
        n_checks++;
        if (ctrl !== m_ctrl_word() || stb_cnt != s0) begin
            n_fail++; $display("FAIL abort_no_write got ctrl %h stb %0d want ctrl %h stb 0",
                               ctrl, stb_cnt - s0, m_ctrl_word());
        end
        model(16, 24'h045A00, exp, es);
        xfer(16, 24'h045A00, 1'b0, got);
        n_checks++;
        if (ctrl !== m_ctrl_word() || stb_cnt - s0 != 1 || wr_addr !== m_wa) begin
            n_fail++; $display("FAIL abort_recover got ctrl %h stb %0d addr %0d want ctrl %h stb 1 addr %0d",
                               ctrl, stb_cnt - s0, wr_addr, m_ctrl_word(), m_wa);
        end
    endtask

    task automatic test_overclock();
        logic [23:0] got, exp; int es, s0;
        s0 = stb_cnt;
        model(24, 24'h0781FF, exp, es);
        xfer(24, 24'h0781FF, 1'b0, got);
        n_checks++;
        if (ctrl[31:24] !== 8'h81 || ctrl !== m_ctrl_word()) begin
            n_fail++; $display("FAIL overclock_ctrl got %h want %h", ctrl, m_ctrl_word());
        end
        n_checks++;
        if (stb_cnt - s0 != 1) begin
            n_fail++; $display("FAIL overclock_stb got %0d want 1", stb_cnt - s0);
        end
        n_checks++;
        if (got[23:16] !== 8'h00) begin
            n_fail++; $display("FAIL overclock_miso_tail got %h want 00", got[23:16]);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] got, exp, fr; int es;
        fr = {8'h06, 8'($urandom), 8'h00};
        model(16, fr, exp, es);
        xfer(16, fr, 1'b0, got);
        fr = 24'h860000;
        model(16, fr, exp, es);
        xfer(16, fr, 1'b0, got);
        n_checks++;
        if (got !== exp) begin
            n_fail++; $display("FAIL back_to_back_ctrl_read got %h want %h", got, exp);
        end
    endtask

    task automatic test_random();
        logic [23:0] got, exp, fr; int es, s0, nb;
        for (int k = 0; k < 16; k++) begin
            status = $urandom;
            fr = {1'($urandom), 4'b0000, 3'($urandom), 8'($urandom), 8'($urandom)};
            case ($urandom_range(0, 3))
                0:       nb = $urandom_range(9, 15);
                1:       nb = $urandom_range(17, 24);
                default: nb = 16;
            endcase
            s0 = stb_cnt;
            model(nb, fr, exp, es);
            xfer(nb, fr, 1'b0, got);
            n_checks++;
            if (got !== exp || stb_cnt - s0 != es || ctrl !== m_ctrl_word() || wr_addr !== m_wa) begin
                n_fail++;
                $display("FAIL random_%0d frame %h bits %0d got miso %h stb %0d ctrl %h addr %0d want miso %h stb %0d ctrl %h addr %0d",
                         k, fr, nb, got, stb_cnt - s0, ctrl, wr_addr, exp, es, m_ctrl_word(), m_wa);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [23:0] got, exp; int es;
        model(16, 24'h053300, exp, es);
        xfer(16, 24'h053300, 1'b0, got);
        xfer(10, 24'h07AA00, 1'b1, got);
        rst = 1'b1;
        #2;
        for (int i = 0; i < 4; i++) m_ctrl[i] = CtrlReset[8*i +: 8];
        m_wa = 2'd0;
        n_checks++;
        if (ctrl !== CtrlReset || {miso, wr_stb, wr_addr} !== 4'b0) begin
            n_fail++; $display("FAIL reset_midframe got ctrl %h out %b want ctrl %h out 0000",
                               ctrl, {miso, wr_stb, wr_addr}, CtrlReset);
        end
        cs_n = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(4);
        status = $urandom;
        model(16, 24'h850000, exp, es);
        xfer(16, 24'h850000, 1'b0, got);
        n_checks++;
        if (got !== exp) begin
            n_fail++; $display("FAIL reset_midframe_read got %h want %h", got, exp);
        end
    endtask

    task automatic test_stall();
        logic [23:0] got, exp; int es, s0, t0;
        s0 = stb_cnt;
        t0 = to_cnt;
        xfer(5, 24'h053C00, 1'b1, got);
        wait_clk(40);
`ifdef DSP_SPI_TIMEOUT_EN
        n_checks++;
        if (to_cnt != t0) begin
            n_fail++; $display("FAIL timeout_early got %0d want 0", to_cnt - t0);
        end
        wait_clk(60);
        n_checks++;
        if (to_cnt - t0 != 1) begin
            n_fail++; $display("FAIL timeout_pulse got %0d want 1", to_cnt - t0);
        end
`else
        wait_clk(160);
        n_checks++;
        if (to_cnt != t0) begin
            n_fail++; $display("FAIL timeout_tied got %0d want 0", to_cnt - t0);
        end
`endif
        cs_n = 1'b1;
        wait_clk(8);
        n_checks++;
        if (ctrl !== m_ctrl_word() || stb_cnt != s0) begin
            n_fail++; $display("FAIL stall_no_write got ctrl %h stb %0d want ctrl %h stb 0",
                               ctrl, stb_cnt - s0, m_ctrl_word());
        end
        model(16, 24'h05C300, exp, es);
        xfer(16, 24'h05C300, 1'b0, got);
        n_checks++;
        if (ctrl !== m_ctrl_word() || stb_cnt - s0 != 1) begin
            n_fail++; $display("FAIL stall_recover got ctrl %h stb %0d want ctrl %h stb 1",
                               ctrl, stb_cnt - s0, m_ctrl_word());
        end
    endtask

    initial begin
        rst    = 1'b1;
        sclk   = 1'b0;
        mosi   = 1'b0;
        cs_n   = 1'b1;
        status = 32'h0;
        for (int i = 0; i < 4; i++) m_ctrl[i] = CtrlReset[8*i +: 8];
        m_wa = 2'd0;
        wait_clk(5);
        test_reset();
        rst = 1'b0;
        wait_clk(4);
        test_write_basic();
        test_read_status();
        test_write_status();
        test_abort();
        test_overclock();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        test_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
